// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared op codes and buffer constants for gate_pipe
package gate_pkg;

  localparam int GATE_OP_W = 3;
  localparam int BUF_DEPTH = 2;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  typedef enum logic [GATE_OP_W-1:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NOT  = 3'd2,
    GATE_NAND = 3'd3,
    GATE_NOR  = 3'd4,
    GATE_XOR  = 3'd5,
    GATE_XNOR = 3'd6,
    GATE_BUF  = 3'd7
  } gate_op_e;

endpackage

// File: rtl/gate_core.sv
// rtl/gate_core.sv - combinational bitwise gate with optional single-bit reduction
// Ports:
//   a, b    WIDTH-bit operands (b unused for NOT and BUF)
//   op      gate_op_e operation select
//   reduce  1 = collapse result to y[0], upper bits zero
//   y       WIDTH-bit result
module gate_core
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  gate_op_e         op,
  input  logic             reduce,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] bitwise;
  logic             red_bit;

  always_comb begin
    bitwise = '0;
    case (op)
      GATE_AND:  bitwise = a & b;
      GATE_OR:   bitwise = a | b;
      GATE_NOT:  bitwise = ~a;
      GATE_NAND: bitwise = ~(a & b);
      GATE_NOR:  bitwise = ~(a | b);
      GATE_XOR:  bitwise = a ^ b;
      GATE_XNOR: bitwise = ~(a ^ b);
      GATE_BUF:  bitwise = a;
      default:   bitwise = '0;
    endcase
  end

  // Inverting ops reduce the non-inverted pairwise vector, then invert once,
  // so e.g. NAND-reduce is ~&(a & b) rather than &(~(a & b)).
  always_comb begin
    red_bit = 1'b0;
    case (op)
      GATE_AND:  red_bit = &(a & b);
      GATE_NAND: red_bit = ~&(a & b);
      GATE_OR:   red_bit = |(a | b);
      GATE_NOR:  red_bit = ~|(a | b);
      GATE_XOR:  red_bit = ^(a ^ b);
      GATE_XNOR: red_bit = ~^(a ^ b);
      GATE_NOT:  red_bit = ~^a;
      GATE_BUF:  red_bit = ^a;
      default:   red_bit = 1'b0;
    endcase
  end

  always_comb begin
    y = '0;
    if (reduce) begin
      y[0] = red_bit;
    end else begin
      y = bitwise;
    end
  end

endmodule

// File: rtl/gate_pipe.sv
// rtl/gate_pipe.sv - registered gate stage with valid/ready handshake and 2-entry output buffer
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             input handshake; in_a, in_b, in_op, in_reduce sampled on accept
//   out_valid/out_ready, out_y    output handshake and head-of-buffer result
//   out_count                     results delivered since reset, wraps at 2^16
module gate_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [GATE_OP_W-1:0] in_op,
  input  logic                 in_reduce,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_y,
  output logic [15:0]          out_count
);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] core_y;
  logic             push;
  logic             pop;

  gate_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (in_a),
    .b      (in_b),
    .op     (gate_op_e'(in_op)),
    .reduce (in_reduce),
    .y      (core_y)
  );

  // in_ready comes only from the registered count, so out_ready never
  // reaches it combinationally; a full buffer frees a slot one cycle after a pop.
  assign in_ready  = (count < CNT_W'(BUF_DEPTH));
  assign out_valid = (count != '0);
  assign out_y     = mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= core_y;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_count <= out_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_pipe.sv
// tb/tb_gate_pipe.sv - self-checking bench for gate_pipe against a queue-based model
module tb_gate_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [2:0]  in_op;
  logic        in_reduce;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_y;
  logic [15:0] out_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  logic [7:0] model_q[$];
  int         model_cnt = 0;
  logic [7:0] log_q[$];

  gate_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_reduce (in_reduce),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference semantics: bit-by-bit truth table, then a fold for reduction.
  function automatic logic [7:0] gate_model(input logic [7:0] a, input logic [7:0] b,
                                             input int op, input bit red);
    logic [7:0] r;
    bit acc;
    for (int i = 0; i < 8; i++) begin
      case (op)
        0: r[i] = a[i] & b[i];
        1: r[i] = a[i] | b[i];
        2: r[i] = !a[i];
        3: r[i] = !(a[i] & b[i]);
        4: r[i] = !(a[i] | b[i]);
        5: r[i] = a[i] ^ b[i];
        6: r[i] = !(a[i] ^ b[i]);
        default: r[i] = a[i];
      endcase
    end
    if (!red) return r;
    acc = (op == 0 || op == 3);
    for (int i = 0; i < 8; i++) begin
      case (op)
        0, 3:    acc = acc & (a[i] & b[i]);
        1, 4:    acc = acc | (a[i] | b[i]);
        5, 6:    acc = acc ^ (a[i] ^ b[i]);
        default: acc = acc ^ a[i];
      endcase
    end
    if (op == 3 || op == 4 || op == 6 || op == 2) acc = !acc;
    return {7'b0, acc};
  endfunction

  // Model advance on the active edge; inputs are stable here (driven #1 after edges).
  always @(posedge clk) begin
    bit do_pop, do_push;
    cyc++;
    if (rst) begin
      model_q.delete();
      model_cnt = 0;
    end else begin
      do_pop  = (model_q.size() > 0) && out_ready;
      do_push = in_valid && (model_q.size() < 2);
      if (do_pop) begin
        void'(model_q.pop_front());
        model_cnt = (model_cnt + 1) % 65536;
      end
      if (do_push) model_q.push_back(gate_model(in_a, in_b, int'(in_op), in_reduce));
    end
  end

  // Compare process on the opposite edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, model_q.size() > 0);
      chk("in_ready", in_ready, model_q.size() < 2);
      chk("out_count", out_count, model_cnt);
      if (model_q.size() > 0) chk("out_y", out_y, model_q[0]);
      if (!rst && out_valid && out_ready) log_q.push_back(out_y);
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input int op, input bit red);
    int n = 0;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_op     = 3'(op);
    in_reduce = red;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_log(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s_%0d", name, i), log_q[i], exp[i]);
    end
    log_q.delete();
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int t0;

    rst = 1'b1; in_valid = 1'b1; in_a = 8'hC5; in_b = 8'h3A; in_op = 3'd0;
    in_reduce = 1'b0; out_ready = 1'b1;

    // Reset held 2 cycles with in_valid high.
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0; in_valid = 1'b0;
    idle(3);
    chk("post_rst_no_result", out_valid, 0);
    chk("post_rst_count", out_count, 0);
    log_q.delete();

    // All ops bitwise.
    for (int op = 0; op < 8; op++) send(8'hC5, 8'h3A, op, 0);
    idle(3);
    exp_q = '{8'h00, 8'hFF, 8'h3A, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hC5};
    chk_log("allops", exp_q);

    // Reduce mode.
    send(8'hFF, 8'hFF, 0, 1);
    send(8'hFF, 8'hFF, 3, 1);
    send(8'hFF, 8'hFF, 5, 1);
    send(8'hFF, 8'hFF, 6, 1);
    send(8'h01, 8'h00, 7, 1);
    idle(3);
    exp_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01};
    chk_log("reduce", exp_q);

    // Backpressure.
    out_ready = 1'b0;
    send(8'h00, 8'h00, 4, 0);
    send(8'h0F, 8'h00, 4, 0);
    fork
      send(8'hFF, 8'hFF, 4, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_y_held", out_y, 8'hFF);
        out_ready = 1'b1;
      end
    join
    idle(4);
    exp_q = '{8'hFF, 8'hF0, 8'h00};
    chk_log("backpressure", exp_q);

    // Streaming 20 items after a fresh reset.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    log_q.delete();
    t0 = cyc;
    for (int i = 0; i < 20; i++) send(8'(i * 7 + 3), 8'h00, 7, 0);
    chk("stream_no_bubbles", cyc - t0, 20);
    idle(3);
    chk("stream_out_count", out_count, 20);
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(i * 7 + 3));
    chk_log("stream", exp_q);

    // Reset with two results buffered.
    out_ready = 1'b0;
    send(8'hAA, 8'h55, 1, 0);
    send(8'hAA, 8'h55, 0, 0);
    in_valid = 1'b0;
    chk("mid_full", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_count", out_count, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(4);
    exp_q.delete();
    chk_log("mid_rst_nothing", exp_q);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
